cpu_mem_responder: RTL and testbench

- Memory-side responder for the 16-bit pipelined CPU.
- Holds the instruction and data memories and serves the CPU's i_addr/i_datain and d_addr/d_we/d_dataout/d_datain ports with zero-latency reads.
- Contains a host-side FSM that preloads both memories over a valid/ready stream, starts the CPU, bounds the run, then streams data memory back to the host.

---
 rtl/cpu_mem_responder.sv | 170 +++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 16-bit pipelined CPU: instruction/data memories plus a host FSM
// that loads, runs and dumps. Optional halt-driven early stop under `HALT_DETECT_EN.
module cpu_mem_responder #(
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 16,
    parameter int unsigned RUN_CYCLES = 1024,
    parameter int unsigned DUMP_WORDS = 256
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          h_valid,
    output logic          h_ready,
    input  logic [DW-1:0] h_data,
    input  logic          h_sel,
    input  logic          h_last,
    input  logic          h_go,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic          cpu_enable,
    output logic          cpu_start,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_datain,
    input  logic [AW-1:0] d_addr,
    input  logic          d_we,
    input  logic [DW-1:0] d_dataout,
    output logic [DW-1:0] d_datain
);

    localparam int unsigned CW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [CW-1:0] RUN_LAST  = CW'(RUN_CYCLES - 1);
    localparam logic [AW-1:0] DUMP_LAST = AW'(DUMP_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StRun, StDump} state_e;

    state_e        state_q;
    logic [AW-1:0] iptr_q;
    logic [AW-1:0] dptr_q;
    logic [AW-1:0] dump_ptr_q;
    logic [CW-1:0] run_cnt_q;

    logic [DW-1:0] imem [2**AW];
    logic [DW-1:0] dmem [2**AW];

    logic host_wr;
    logic cpu_wr;
    logic run_expire;
    logic halt_end;

    assign host_wr    = h_valid & h_ready & (state_q == StIdle);
    assign cpu_wr     = d_we & ((state_q == StStart) | (state_q == StRun));
    assign run_expire = (run_cnt_q == RUN_LAST);

    assign i_datain = imem[i_addr];
    assign d_datain = dmem[d_addr];
    // dmem is not written in DUMP, so o_data holds while the pointer is stalled.
    assign o_data   = o_valid ? dmem[dump_ptr_q] : '0;

`ifdef HALT_DETECT_EN
    logic       halt_seen_q;
    logic [2:0] drain_q;

    assign halt_end = halt_seen_q & (drain_q == 3'd1);
`else
    assign halt_end = 1'b0;
`endif

    // Host and CPU writes are exclusive by state, so dmem needs only one port at a time.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (host_wr && !h_sel) imem[iptr_q] <= h_data;
            if (host_wr && h_sel) begin
                dmem[dptr_q] <= h_data;
            end else if (cpu_wr) begin
                dmem[d_addr] <= d_dataout;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            h_ready    <= 1'b1;
            o_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            cpu_enable <= 1'b0;
            cpu_start  <= 1'b0;
            iptr_q     <= '0;
            dptr_q     <= '0;
            dump_ptr_q <= '0;
            run_cnt_q  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (host_wr) begin
                        if (h_last) begin
                            iptr_q <= '0;
                            dptr_q <= '0;
                        end else if (h_sel) begin
                            dptr_q <= dptr_q + 1'b1;
                        end else begin
                            iptr_q <= iptr_q + 1'b1;
                        end
                    end
                    if (h_go) begin
                        state_q    <= StStart;
                        h_ready    <= 1'b0;
                        busy       <= 1'b1;
                        timeout    <= 1'b0;
                        cpu_enable <= 1'b1;
                        cpu_start  <= 1'b1;
                    end
                end
                StStart: begin
                    state_q   <= StRun;
                    cpu_start <= 1'b0;
                    run_cnt_q <= '0;
                end
                StRun: begin
                    run_cnt_q <= run_cnt_q + 1'b1;
                    if (run_expire || halt_end) begin
                        state_q    <= StDump;
                        cpu_enable <= 1'b0;
                        o_valid    <= 1'b1;
                        timeout    <= run_expire;
                    end
                end
                StDump: begin
                    if (o_ready) begin
                        if (dump_ptr_q == DUMP_LAST) begin
                            state_q    <= StIdle;
                            o_valid    <= 1'b0;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            h_ready    <= 1'b1;
                            dump_ptr_q <= '0;
                        end else begin
                            dump_ptr_q <= dump_ptr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef HALT_DETECT_EN
    // Drain lets instructions already in the CPU pipeline retire before the dump.
    always_ff @(posedge clock) begin
        if (reset || state_q == StStart) begin
            halt_seen_q <= 1'b0;
            drain_q     <= '0;
        end else if (state_q == StRun) begin
            if (!halt_seen_q && i_datain[15:11] == 5'b00001) begin
                halt_seen_q <= 1'b1;
                drain_q     <= 3'd4;
            end else if (halt_seen_q && drain_q != 3'd0) begin
                drain_q <= drain_q - 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: load, run with a CPU write, stalled dump, reset mid-run.
module tb_cpu_mem_responder;

    logic        clock;
    logic        reset;
    logic        h_valid;
    logic        h_ready;
    logic [15:0] h_data;
    logic        h_sel;
    logic        h_last;
    logic        h_go;
    logic        o_valid;
    logic        o_ready;
    logic [15:0] o_data;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        cpu_enable;
    logic        cpu_start;
    logic [7:0]  i_addr;
    logic [15:0] i_datain;
    logic [7:0]  d_addr;
    logic        d_we;
    logic [15:0] d_dataout;
    logic [15:0] d_datain;

    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0;
    int done_cnt  = 0;

    cpu_mem_responder #(
        .AW(8),
        .DW(16),
        .RUN_CYCLES(16),
        .DUMP_WORDS(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .h_valid(h_valid),
        .h_ready(h_ready),
        .h_data(h_data),
        .h_sel(h_sel),
        .h_last(h_last),
        .h_go(h_go),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_data(o_data),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .cpu_enable(cpu_enable),
        .cpu_start(cpu_start),
        .i_addr(i_addr),
        .i_datain(i_datain),
        .d_addr(d_addr),
        .d_we(d_we),
        .d_dataout(d_dataout),
        .d_datain(d_datain)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (cpu_start) start_cnt++;
        if (done) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic [15:0] data, input logic sel, input logic last);
        h_valid = 1'b1;
        h_data  = data;
        h_sel   = sel;
        h_last  = last;
        tick();
        h_valid = 1'b0;
        h_last  = 1'b0;
    endtask

    logic [15:0] exp_d [8];
    logic        rdy [4];

    initial begin
        int cyc;
        int idx;
        int k;
        int s0;
        int d0;
        logic        stalled;
        logic [15:0] held;

        reset = 1'b1; h_valid = 0; h_data = 0; h_sel = 0; h_last = 0; h_go = 0;
        o_ready = 0; i_addr = 0; d_addr = 0; d_we = 0; d_dataout = 0;
        rdy[0] = 1; rdy[1] = 0; rdy[2] = 0; rdy[3] = 1;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_h_ready", 32'(h_ready), 32'd1);
        check_eq("rst_o_valid", 32'(o_valid), 32'd0);
        check_eq("rst_o_data", 32'(o_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_timeout", 32'(timeout), 32'd0);
        check_eq("rst_cpu_en", 32'(cpu_enable), 32'd0);
        check_eq("rst_cpu_start", 32'(cpu_start), 32'd0);

        // Instruction load, last clears pointer, next beat lands at address 0.
        beat(16'h4A12, 1'b0, 1'b0);
        beat(16'h0000, 1'b0, 1'b0);
        beat(16'h0800, 1'b0, 1'b1);
        i_addr = 8'd0; #1 check_eq("imem0", 32'(i_datain), 32'h4A12);
        i_addr = 8'd1; #1 check_eq("imem1", 32'(i_datain), 32'h0000);
        i_addr = 8'd2; #1 check_eq("imem2", 32'(i_datain), 32'h0800);
        beat(16'h1111, 1'b0, 1'b1);
        i_addr = 8'd0; #1 check_eq("imem0_rewrite", 32'(i_datain), 32'h1111);
        i_addr = 8'd2; #1 check_eq("imem2_kept", 32'(i_datain), 32'h0800);

        for (int i = 0; i < 8; i++) begin
            exp_d[i] = (i == 0) ? 16'h1234 : 16'hD000 + 16'(i);
            beat(exp_d[i], 1'b1, i == 7);
        end
        d_addr = 8'd3; #1 check_eq("dmem3_load", 32'(d_datain), 32'hD003);

        // Run: go held through RUN must be ignored, as must host beats.
        s0 = start_cnt;
        d0 = done_cnt;
        h_go = 1'b1;
        tick();
        check_eq("start_cpu_start", 32'(cpu_start), 32'd1);
        check_eq("start_cpu_en", 32'(cpu_enable), 32'd1);
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_h_ready", 32'(h_ready), 32'd0);
        tick();
        check_eq("run_cpu_start", 32'(cpu_start), 32'd0);
        check_eq("run_cpu_en", 32'(cpu_enable), 32'd1);
        d_we = 1'b1; d_addr = 8'd5; d_dataout = 16'hBEEF;
        h_valid = 1'b1; h_sel = 1'b1; h_data = 16'hDEAD;
        #1 check_eq("run_h_ready", 32'(h_ready), 32'd0);
        tick();
        d_we = 1'b0;
        #1 check_eq("cpu_write", 32'(d_datain), 32'hBEEF);
        d_addr = 8'd0;
        #1 check_eq("host_blocked", 32'(d_datain), 32'h1234);

        cyc = 0;
        while (!o_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        h_valid = 1'b0;
        h_go = 1'b0;
        check_eq("run_length", 32'(cyc), 32'd15);
        check_eq("dump_timeout", 32'(timeout), 32'd1);
        check_eq("dump_cpu_en", 32'(cpu_enable), 32'd0);
        check_eq("dump_busy", 32'(busy), 32'd1);

        exp_d[5] = 16'hBEEF;
        idx = 0;
        k = 0;
        stalled = 1'b0;
        held = '0;
        while (idx < 8 && k < 100) begin
            o_ready = rdy[k % 4];
            #1;
            if (stalled && o_valid) check_eq("dump_hold", 32'(o_data), 32'(held));
            if (o_valid) begin
                if (o_ready) begin
                    check_eq($sformatf("dump_word%0d", idx), 32'(o_data), 32'(exp_d[idx]));
                    idx++;
                    stalled = 1'b0;
                end else begin
                    held = o_data;
                    stalled = 1'b1;
                end
            end
            tick();
            k++;
        end
        o_ready = 1'b0;
        check_eq("dump_count", 32'(idx), 32'd8);
        check_eq("done_now", 32'(done), 32'd1);
        check_eq("idle_o_valid", 32'(o_valid), 32'd0);
        tick();
        tick();
        tick();
        check_eq("done_pulses", 32'(done_cnt - d0), 32'd1);
        check_eq("start_pulses", 32'(start_cnt - s0), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_h_ready", 32'(h_ready), 32'd1);
        check_eq("timeout_sticky", 32'(timeout), 32'd1);

        // Second run aborted by reset mid-RUN.
        h_go = 1'b1;
        tick();
        h_go = 1'b0;
        check_eq("go2_timeout_clr", 32'(timeout), 32'd0);
        tick();
        tick();
        tick();
        check_eq("run2_cpu_en", 32'(cpu_enable), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_cpu_en", 32'(cpu_enable), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_o_valid", 32'(o_valid), 32'd0);
        check_eq("abort_h_ready", 32'(h_ready), 32'd1);
        i_addr = 8'd0; #1 check_eq("abort_imem0", 32'(i_datain), 32'h1111);
        i_addr = 8'd2; #1 check_eq("abort_imem2", 32'(i_datain), 32'h0800);
        d_addr = 8'd5; #1 check_eq("abort_dmem5", 32'(d_datain), 32'hBEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
